// File: rtl/i2c_dri.sv
// i2c_dri: I2C master bit driver, one single-byte E2PROM random write or read per command.
// Ports: dri_clk/rst_n; i2c_exec + bit_ctrl/i2c_rh_wl/i2c_addr/i2c_data_w in; i2c_data_r/i2c_done/i2c_ack out; scl, sda (open-drain).
module i2c_dri #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned I2C_FREQ   = 250_000,
  parameter logic [6:0]  SLAVE_ADDR = 7'b1010000
) (
  input  logic        dri_clk,
  input  logic        rst_n,
  input  logic        i2c_exec,
  input  logic        bit_ctrl,
  input  logic        i2c_rh_wl,
  input  logic [15:0] i2c_addr,
  input  logic [7:0]  i2c_data_w,
  output logic [7:0]  i2c_data_r,
  output logic        i2c_done,
  output logic        i2c_ack,
  output logic        scl,
  inout  wire         sda
);

  localparam int unsigned DIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] START     = 4'd1;
  localparam logic [3:0] SLADDR    = 4'd2;
  localparam logic [3:0] ADDR_H    = 4'd3;
  localparam logic [3:0] ADDR_L    = 4'd4;
  localparam logic [3:0] DATA_WR   = 4'd5;
  localparam logic [3:0] RSTART    = 4'd6;
  localparam logic [3:0] SLADDR_RD = 4'd7;
  localparam logic [3:0] DATA_RD   = 4'd8;
  localparam logic [3:0] STOP      = 4'd9;

  logic [3:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic          b16_q, b16_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_r_q, data_r_d;
  logic          ack_q, ack_d;
  logic          scl_q, scl_d;
  logic          oe_q, oe_d;
  logic          fin_q, fin_d;
  logic          done_q, done_d;
  logic          sda_meta_q, sda_sync_q;

  logic       tick, samp, cell_end;
  logic       ack_slot, byte_st, start_st;
  logic [7:0] tx_byte;
  logic       tx_bit;

  always_comb begin
    tick     = (div_q == DIV_LAST);
    samp     = tick && (qtr_q == 2'd2);
    cell_end = tick && (qtr_q == 2'd3);
    ack_slot = (bit_q == 4'd8);
    start_st = (state_q == START) || (state_q == RSTART);
    byte_st  = (state_q == SLADDR) || (state_q == ADDR_H) ||
               (state_q == ADDR_L) || (state_q == DATA_WR) ||
               (state_q == SLADDR_RD);

    case (state_q)
      SLADDR:    tx_byte = {SLAVE_ADDR, 1'b0};
      ADDR_H:    tx_byte = addr_q[15:8];
      ADDR_L:    tx_byte = addr_q[7:0];
      DATA_WR:   tx_byte = wdata_q;
      SLADDR_RD: tx_byte = {SLAVE_ADDR, 1'b1};
      default:   tx_byte = 8'h00;
    endcase
    tx_bit = tx_byte[3'd7 - bit_q[2:0]];

    // Bus levels for the current quarter; registered, so the pins
    // trail the sequencer by one clock.
    scl_d = 1'b1;
    oe_d  = 1'b0;
    unique case (1'b1)
      start_st: begin
        scl_d = (qtr_q != 2'd3);
        oe_d  = qtr_q[1];
      end
      state_q == STOP: begin
        scl_d = (qtr_q != 2'd0);
        oe_d  = !qtr_q[1];
      end
      byte_st || (state_q == DATA_RD): begin
        scl_d = ^qtr_q;
        oe_d  = byte_st && !ack_slot && !tx_bit;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    div_d    = tick ? '0 : div_q + 1'b1;
    qtr_d    = tick ? qtr_q + 2'd1 : qtr_q;
    bit_d    = bit_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    b16_d    = b16_q;
    shift_d  = shift_q;
    data_r_d = data_r_q;
    ack_d    = ack_q;
    fin_d    = 1'b0;
    done_d   = fin_q;

    if (state_q == IDLE) begin
      div_d = '0;
      qtr_d = '0;
      bit_d = '0;
      if (i2c_exec) begin
        addr_d  = i2c_addr;
        wdata_d = i2c_data_w;
        rd_d    = i2c_rh_wl;
        b16_d   = bit_ctrl;
        ack_d   = 1'b0;
        state_d = START;
      end
    end else begin
      if (samp) begin
        if ((state_q == DATA_RD) && !ack_slot)
          shift_d = {shift_q[6:0], sda_sync_q};
        if (byte_st && ack_slot && sda_sync_q)
          ack_d = 1'b1;
      end
      if (cell_end) begin
        case (state_q)
          START:  state_d = SLADDR;
          RSTART: state_d = SLADDR_RD;
          STOP: begin
            state_d = IDLE;
            fin_d   = 1'b1;
          end
          default: begin
            if (!ack_slot) begin
              bit_d = bit_q + 4'd1;
            end else begin
              bit_d = '0;
              // A NACK on any slave slot abandons the rest.
              if (state_q == DATA_RD) begin
                data_r_d = shift_q;
                state_d  = STOP;
              end else if (ack_q) begin
                state_d = STOP;
              end else if (state_q == SLADDR) begin
                state_d = b16_q ? ADDR_H : ADDR_L;
              end else if (state_q == ADDR_H) begin
                state_d = ADDR_L;
              end else if (state_q == ADDR_L) begin
                state_d = rd_q ? RSTART : DATA_WR;
              end else if (state_q == SLADDR_RD) begin
                state_d = DATA_RD;
              end else begin
                state_d = STOP;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge dri_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      qtr_q      <= '0;
      bit_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      b16_q      <= 1'b0;
      shift_q    <= '0;
      data_r_q   <= '0;
      ack_q      <= 1'b0;
      scl_q      <= 1'b1;
      oe_q       <= 1'b0;
      fin_q      <= 1'b0;
      done_q     <= 1'b0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      b16_q      <= b16_d;
      shift_q    <= shift_d;
      data_r_q   <= data_r_d;
      ack_q      <= ack_d;
      scl_q      <= scl_d;
      oe_q       <= oe_d;
      fin_q      <= fin_d;
      done_q     <= done_d;
      sda_meta_q <= sda;
      sda_sync_q <= sda_meta_q;
    end
  end

  assign scl        = scl_q;
  assign sda        = oe_q ? 1'b0 : 1'bz;
  assign i2c_data_r = data_r_q;
  assign i2c_done   = done_q;
  assign i2c_ack    = ack_q;

endmodule

// File: tb/tb_i2c_dri.sv
// tb_i2c_dri: directed + random transactions against a byte-level slave model.
// Bus events (START, STOP, byte+ack) are compared with an expected list built per command.
module tb_i2c_dri;

  localparam int P     = 200;
  localparam int EV_S  = 1000;
  localparam int EV_P  = 1001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exec = 1'b0;
  logic        bc = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wd = '0;
  logic [7:0]  dr;
  logic        done, ack, scl;
  wire         sda_w;

  pullup (sda_w);

  logic s_drv = 1'b0;
  assign sda_w = s_drv ? 1'b0 : 1'bz;

  i2c_dri dut (
    .dri_clk    (clk),
    .rst_n      (rst_n),
    .i2c_exec   (exec),
    .bit_ctrl   (bc),
    .i2c_rh_wl  (rw),
    .i2c_addr   (addr),
    .i2c_data_w (wd),
    .i2c_data_r (dr),
    .i2c_done   (done),
    .i2c_ack    (ack),
    .scl        (scl),
    .sda        (sda_w)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ev_q[$];
  int exp_q[$];
  int done_cnt = 0;
  logic [7:0] exp_r = '0;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  // Slave model: ACKs written bytes when present; serves one byte
  // after a read address.
  logic       s_present = 1'b1;
  logic [7:0] s_rdata = '0;
  int         s_bitn = 0;
  int         s_byte = 0;
  logic [7:0] s_sh = '0;
  logic       s_tx = 1'b0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;

  always @(scl or sda_w) begin
    if (scl === p_scl && sda_w !== p_sda) begin
      if (scl === 1'b1) begin
        ev_q.push_back((sda_w === 1'b0) ? EV_S : EV_P);
        s_bitn = 0;
        s_byte = 0;
        s_tx   = 1'b0;
        s_drv  = 1'b0;
      end
    end else if (scl !== p_scl) begin
      if (scl === 1'b1) begin
        if (s_bitn < 8) s_sh = {s_sh[6:0], sda_w};
        else ev_q.push_back(int'({s_sh, sda_w}));
        s_bitn++;
      end else begin
        if (s_bitn == 8) begin
          s_drv = !s_tx && s_present;
        end else if (s_bitn == 9) begin
          s_bitn = 0;
          if (s_byte == 0 && s_sh[0] && s_present) begin
            s_tx  = 1'b1;
            s_drv = !s_rdata[7];
          end else begin
            s_tx  = 1'b0;
            s_drv = 1'b0;
          end
          s_byte++;
        end else if (s_tx && s_bitn >= 1 && s_bitn <= 7) begin
          s_drv = !s_rdata[7 - s_bitn];
        end
      end
    end
    p_scl = scl;
    p_sda = sda_w;
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bev(input logic [7:0] b, input logic a);
    return int'({b, a});
  endfunction

  // Expected bus transcript; returns length in SCL periods.
  function automatic int build_exp(input logic r, input logic b,
                                   input logic [15:0] a,
                                   input logic [7:0] w,
                                   input logic [7:0] d,
                                   input logic pres);
    int per;
    exp_q.delete();
    exp_q.push_back(EV_S);
    exp_q.push_back(bev(8'hA0, !pres));
    if (pres) begin
      if (b) exp_q.push_back(bev(a[15:8], 1'b0));
      exp_q.push_back(bev(a[7:0], 1'b0));
      if (r) begin
        exp_q.push_back(EV_S);
        exp_q.push_back(bev(8'hA1, 1'b0));
        exp_q.push_back(bev(d, 1'b1));
      end else begin
        exp_q.push_back(bev(w, 1'b0));
      end
    end
    exp_q.push_back(EV_P);
    per = 0;
    foreach (exp_q[i]) per += (exp_q[i] >= EV_S) ? 1 : 9;
    return per;
  endfunction

  task automatic run_txn(input string tag, input logic t_rw,
                         input logic t_bc, input logic [15:0] t_a,
                         input logic [7:0] t_wd, input logic [7:0] t_rd,
                         input logic pres, input int poke_at,
                         input int rst_at);
    int n, per, d0, ev_base, obs;
    bit got;
    s_present = pres;
    s_rdata   = t_rd;
    per = build_exp(t_rw, t_bc, t_a, t_wd, t_rd, pres);
    @(negedge clk);
    ev_base = ev_q.size();
    d0   = done_cnt;
    exec = 1'b1;
    rw   = t_rw;
    bc   = t_bc;
    addr = t_a;
    wd   = t_wd;
    @(posedge clk);
    #1;
    exec = 1'b0;
    rw   = 1'($urandom_range(0, 1));
    bc   = 1'($urandom_range(0, 1));
    addr = 16'($urandom);
    wd   = 8'($urandom);
    n   = 0;
    got = 1'b0;
    while (!got && n < per * P + 500) begin
      @(posedge clk);
      #1;
      n++;
      exec = 1'b0;
      if (n == poke_at) begin
        exec = 1'b1;
        rw   = ~t_rw;
        bc   = ~t_bc;
        addr = ~t_a;
        wd   = ~t_wd;
      end
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, ":rst_scl"}, int'(scl), 1);
        check({tag, ":rst_sda"}, int'(sda_w), 1);
        check({tag, ":rst_done"}, int'(done), 0);
        check({tag, ":rst_ack"}, int'(ack), 0);
        check({tag, ":rst_data_r"}, int'(dr), 0);
        exp_r = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        return;
      end
      if (done === 1'b1) got = 1'b1;
    end
    check({tag, ":done_latency"}, n, per * P + 1);
    if (t_rw && pres) exp_r = t_rd;
    check({tag, ":ack"}, int'(ack), int'(!pres));
    check({tag, ":data_r"}, int'(dr), int'(exp_r));
    @(posedge clk);
    #1;
    check({tag, ":done_width"}, int'(done), 0);
    repeat (20) @(posedge clk);
    #1;
    check({tag, ":done_count"}, done_cnt - d0, 1);
    check({tag, ":idle_scl"}, int'(scl), 1);
    check({tag, ":ev_count"}, ev_q.size() - ev_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (ev_base + i < ev_q.size()) ? ev_q[ev_base + i] : -1;
      check($sformatf("%s:ev%0d", tag, i), obs, exp_q[i]);
    end
  endtask

  initial begin
    logic        r_rw, r_bc;
    logic [15:0] r_a;
    logic [7:0]  r_w, r_d;
    rst_n = 1'b1;
    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset:scl", int'(scl), 1);
    check("reset:sda", int'(sda_w), 1);
    check("reset:data_r", int'(dr), 0);
    check("reset:done", int'(done), 0);
    check("reset:ack", int'(ack), 0);

    run_txn("wr16", 1'b0, 1'b1, 16'h0123, 8'hA5, 8'h00, 1'b1, 0, 0);
    run_txn("rd16", 1'b1, 1'b1, 16'h00FF, 8'h00, 8'h3C, 1'b1, 0, 0);
    run_txn("wr8", 1'b0, 1'b0, 16'h1234, 8'h55, 8'h00, 1'b1, 0, 0);
    run_txn("nack", 1'b1, 1'b1, 16'h0456, 8'h00, 8'h99, 1'b0, 0, 0);
    run_txn("busy", 1'b0, 1'b1, 16'hBEEF, 8'h5A, 8'h00, 1'b1, 3000, 0);
    run_txn("midrst", 1'b0, 1'b1, 16'h0F0F, 8'hC3, 8'h00, 1'b1, 0, 4000);
    run_txn("after_rst", 1'b1, 1'b1, 16'h7E81, 8'h00, 8'hD2, 1'b1, 0, 0);

    for (int k = 0; k < 2; k++) begin
      r_rw = 1'($urandom_range(0, 1));
      r_bc = 1'($urandom_range(0, 1));
      r_a  = 16'($urandom);
      r_w  = 8'($urandom);
      r_d  = 8'($urandom);
      run_txn($sformatf("rand%0d", k), r_rw, r_bc, r_a, r_w, r_d,
              1'b1, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_dri.md
# i2c_dri

I2C master bit-level driver for the E2PROM subsystem. It accepts one command at a time on the `i2c_exec` command interface from the E2PROM read/write controller and performs a single-byte random write or random read on the bus. It generates SCL and open-drain SDA, then returns read data, an acknowledge-error flag and a done pulse. Only a single master is supported; clock stretching is not supported.

## Interface
- `CLK_FREQ`, 50_000_000: `dri_clk` frequency in Hz.
- `I2C_FREQ`, 250_000: SCL frequency in Hz.
- `SLAVE_ADDR`, 7'b1010000: 7-bit device address.
- Derived, not a port: `DIV = CLK_FREQ/(4*I2C_FREQ)` (50 at defaults), which is `dri_clk` cycles per SCL quarter-period.

Ports:
- `dri_clk`, in, 1: the single clock. One clock; reset is asynchronous and active-low.
- `rst_n`, in, 1: asynchronous active-low reset.
- `i2c_exec`, in, 1: start a transaction when sampled high while IDLE.
- `bit_ctrl`, in, 1: register address width; 1 = 16-bit, 0 = 8-bit.
- `i2c_rh_wl`, in, 1: 1 = read, 0 = write.
- `i2c_addr`, in, 16: E2PROM byte address.
- `i2c_data_w`, in, 8: write data.
- `i2c_data_r`, out, 8: last byte read.
- `i2c_done`, out, 1: one-cycle pulse at transaction end.
- `i2c_ack`, out, 1: 1 = a slave ACK slot sampled SDA high (NACK) in the last transaction.
- `scl`, out, 1: SCL, push-pull.
- `sda`, inout, 1: SDA, open-drain. The block drives 0 or Z and never drives 1.

## Operation
- **Reset values:**
  - `scl`=1, `sda`=Z.
  - `i2c_data_r`=0, `i2c_done`=0, `i2c_ack`=0.
  - State IDLE; quarter counter and divider at 0.
- **Command accept:**
  - In IDLE, `i2c_exec`=1 latches `i2c_addr`, `i2c_data_w`, `i2c_rh_wl`, `bit_ctrl` into shadow registers and clears `i2c_ack`.
  - The inputs are don't-care afterwards.
  - `i2c_exec` outside IDLE is ignored and not queued.
- **States:**
  - IDLE
  - START
  - SLADDR: SLAVE_ADDR + write bit 0.
  - ADDR_H: `addr[15:8]`. Skipped when `bit_ctrl`=0.
  - ADDR_L: `addr[7:0]`.
  - Write path: ADDR_L → DATA_WR → STOP.
  - Read path: ADDR_L → RSTART → SLADDR_RD (SLAVE_ADDR + 1) → DATA_RD → STOP.
  - STOP → IDLE.
- **Bytes:** every byte is 8 bits MSB first, then an ACK slot.
  - Slave ACK slots in all states except DATA_RD: SDA released; SDA sampled high → set `i2c_ack`=1 and go straight to STOP, skipping the remaining bytes.
  - DATA_RD: the slave drives 8 bits; the master sends NACK (SDA released) in the 9th slot.
  - `i2c_data_r` is updated with the shifted byte at the end of that 9th slot. It holds otherwise, including on NACK-aborted reads.
- **Bit cell:** each SCL period is 4 quarters of DIV cycles.
  - q0: SCL low, SDA changes.
  - q1: SCL rises.
  - q2: SDA sampled, mid-high.
  - q3: SCL falls.
- **START / RSTART:**
  - q0: SDA released, SCL high (RSTART raises SCL here).
  - q1: SCL high.
  - q2: SDA pulled low.
  - q3: SCL low.
- **STOP:**
  - q0: SDA low, SCL low.
  - q1: SCL high.
  - q2: SDA released.
  - q3: hold.
- **Bus rule:** SDA never changes while SCL is high, except in START/RSTART/STOP.
- **Done:** after STOP q3, `i2c_done`=1 for exactly one cycle with state IDLE. `i2c_exec` in that same cycle is accepted.
- **Reset mid-transaction:** all outputs return to reset values immediately. The bus is left released with no STOP issued.

## Timing
- Transaction length in SCL periods (P = 4·DIV `dri_clk` cycles):
  - Write, 16-bit address: 38.
  - Write, 8-bit address: 29.
  - Read, 16-bit address: 48.
  - Read, 8-bit address: 39.
- Exec accepted at edge k → first SCL/SDA activity at k+1; `i2c_done` high during cycle k + N·P + 1.
- NACK at the SLADDR ACK slot: `i2c_done` after START + 9 bit periods + STOP, i.e. 11·P + 1 cycles.
- Divider counts 0..DIV−1; a quarter advances at DIV−1.
- The divider is free of `i2c_exec` timing: it resets to 0 on accept.
- `i2c_ack` and `i2c_data_r` are valid from the `i2c_done` cycle until the next accept.

## Test plan
- **16-bit write:** ACKing slave model; write `i2c_addr`=0x0123, `i2c_data_w`=0xA5 → bus bytes A0, 01, 23, A5. `i2c_ack`=0. `i2c_done` at 38·200+1 cycles; SDA stable while SCL high except START/STOP.
- **16-bit read:** slave returns 0x3C; read at 0x00FF, `bit_ctrl`=1 → bytes A0, 00, FF, repeated start, A1. Master NACKs the data byte. `i2c_data_r`=0x3C, `i2c_done` at 48·200+1.
- **8-bit address:** `bit_ctrl`=0, write 0x1234/0x55 → bytes A0, 34, 55 only. `i2c_done` at 29·200+1.
- **Device-address NACK:** slave absent (SDA pulled high) → STOP right after the first byte. `i2c_ack`=1, `i2c_done` at 11·200+1, `i2c_data_r` unchanged.
- **Exec while busy:** second `i2c_exec` mid-write → ignored. Exactly one `i2c_done`; the bus carries the first command only.
- **Reset mid-transfer:** `rst_n` low during ADDR_L → `scl`=1 and `sda`=Z at once, `i2c_done`=0. A subsequent exec runs a clean full transaction.
